xspi_xfer_arbiter: RTL and testbench

XSPI_XFER_ARBITER -- requirements
Module: xspi_xfer_arbiter

---
 rtl/xspi_arb_pkg.sv | 15 +
 rtl/xspi_xfer_arbiter.sv | 130 +++++++++++++
 tb/tb_xspi_xfer_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/xspi_arb_pkg.sv
// Shared encodings for the xSPI transfer arbiter: FSM states, owner select
// values and the default timeout-counter width.
package xspi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } arb_state_e;

  localparam logic SEL_CSR   = 1'b0;
  localparam logic SEL_MEM   = 1'b1;
  localparam int   TMO_W_DEF = 16;

endpackage

// File: rtl/xspi_xfer_arbiter.sv
// Arbitrates the CSR and AXI-memory paths for the single xSPI sequencer:
// grant, transfer watchdog and CS# inter-transfer hold.
module xspi_xfer_arbiter
  import xspi_arb_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             mem_clk,
  input  logic             mem_rst_n,
  input  logic             csr_req_i,
  input  logic             mem_req_i,
  input  logic             mem_prio_i,
  input  logic [3:0]       cs_hold_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic             seq_done_i,
  output logic             csr_gnt_o,
  output logic             mem_gnt_o,
  output logic             seq_start_o,
  output logic             seq_sel_o,
  output logic             seq_abort_o,
  output logic             csr_done_o,
  output logic             mem_done_o,
  output logic             tmo_err_o,
  output logic             busy_o
);

  arb_state_e       state_q, state_d;
  logic             last_sel_q, last_sel_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic             csr_done_q, csr_done_d;
  logic             mem_done_q, mem_done_d;

  logic             winner;
  logic             tmo_hit;

  // Fixed priority favours MEM; otherwise alternate away from the last owner.
  always_comb begin
    winner = SEL_CSR;
    if (csr_req_i && mem_req_i) winner = mem_prio_i ? SEL_MEM : ~last_sel_q;
    else if (mem_req_i)         winner = SEL_MEM;
  end

  assign tmo_hit = (tmo_limit_i != '0) && (tmo_cnt_q == tmo_limit_i);

  always_comb begin
    state_d    = state_q;
    last_sel_d = last_sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    hold_cnt_d = hold_cnt_q;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    err_d      = 1'b0;
    csr_done_d = 1'b0;
    mem_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (csr_req_i || mem_req_i) begin
          state_d    = ST_ACTIVE;
          last_sel_d = winner;
          tmo_cnt_d  = '0;
          start_d    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        // A done arriving on the timeout cycle still completes normally.
        if (seq_done_i || tmo_hit) begin
          if (seq_done_i) begin
            csr_done_d = (last_sel_q == SEL_CSR);
            mem_done_d = (last_sel_q == SEL_MEM);
          end else begin
            abort_d = 1'b1;
            err_d   = 1'b1;
          end
          hold_cnt_d = cs_hold_i;
          state_d    = (cs_hold_i == 4'd0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q <= 4'd1) begin
          hold_cnt_d = 4'd0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q    <= ST_IDLE;
      last_sel_q <= SEL_MEM;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= 4'd0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      csr_done_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
      tmo_cnt_q  <= tmo_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      csr_done_q <= csr_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  // last_sel doubles as the current owner from grant until the next grant.
  assign busy_o      = (state_q != ST_IDLE);
  assign csr_gnt_o   = (state_q == ST_ACTIVE) && (last_sel_q == SEL_CSR);
  assign mem_gnt_o   = (state_q == ST_ACTIVE) && (last_sel_q == SEL_MEM);
  assign seq_sel_o   = busy_o && last_sel_q;
  assign seq_start_o = start_q;
  assign seq_abort_o = abort_q;
  assign tmo_err_o   = err_q;
  assign csr_done_o  = csr_done_q;
  assign mem_done_o  = mem_done_q;

endmodule

// File: tb/tb_xspi_xfer_arbiter.sv
// Directed bench for xspi_xfer_arbiter: a transaction table checked cycle by
// cycle, plus hand sequences for reset, idle done and back-to-back arbitration.
module tb_xspi_xfer_arbiter;

  logic        mem_clk = 1'b0;
  logic        mem_rst_n = 1'b0;
  logic        csr_req_i = 1'b0, mem_req_i = 1'b0, mem_prio_i = 1'b0;
  logic [3:0]  cs_hold_i = 4'd0;
  logic [15:0] tmo_limit_i = 16'd0;
  logic        seq_done_i = 1'b0;
  logic        csr_gnt_o, mem_gnt_o, seq_start_o, seq_sel_o, seq_abort_o;
  logic        csr_done_o, mem_done_o, tmo_err_o, busy_o;

  xspi_xfer_arbiter #(.TMO_W(16)) dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
    .csr_req_i(csr_req_i), .mem_req_i(mem_req_i), .mem_prio_i(mem_prio_i),
    .cs_hold_i(cs_hold_i), .tmo_limit_i(tmo_limit_i), .seq_done_i(seq_done_i),
    .csr_gnt_o(csr_gnt_o), .mem_gnt_o(mem_gnt_o), .seq_start_o(seq_start_o),
    .seq_sel_o(seq_sel_o), .seq_abort_o(seq_abort_o), .csr_done_o(csr_done_o),
    .mem_done_o(mem_done_o), .tmo_err_o(tmo_err_o), .busy_o(busy_o)
  );

  always #5 mem_clk = ~mem_clk;

  // {csr_gnt, mem_gnt, start, sel, abort, csr_done, mem_done, err, busy}
  logic [8:0] ov;
  assign ov = {csr_gnt_o, mem_gnt_o, seq_start_o, seq_sel_o, seq_abort_o,
               csr_done_o, mem_done_o, tmo_err_o, busy_o};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        csr, mem, prio;
    logic [3:0]  hold;
    logic [15:0] tmo;
    int          dly;      // cycles after grant cycle to raise done; -1 = never
    logic        exp_sel;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mkv(logic c, logic m, logic p, logic [3:0] h,
                               logic [15:0] t, int d, logic s);
    vec_t v;
    v.csr = c; v.mem = m; v.prio = p; v.hold = h; v.tmo = t; v.dly = d; v.exp_sel = s;
    return v;
  endfunction

  function automatic logic [8:0] mk(logic gc, logic gm, logic st, logic sl, logic ab,
                                    logic dc, logic dm, logic er, logic bz);
    return {gc, gm, st, sl, ab, dc, dm, er, bz};
  endfunction

  task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic run_vec(int i);
    vec_t v;
    bit   to, gnt, fin, bz;
    int   endc;
    v    = tbl[i];
    to   = !(v.dly >= 0 && (v.tmo == 16'd0 || v.dly <= int'(v.tmo)));
    endc = to ? int'(v.tmo) + 1 : v.dly + 1;
    @(negedge mem_clk);
    csr_req_i = v.csr; mem_req_i = v.mem; mem_prio_i = v.prio;
    cs_hold_i = v.hold; tmo_limit_i = v.tmo;
    @(negedge mem_clk);
    csr_req_i = 1'b0; mem_req_i = 1'b0;
    chk($sformatf("v%0d grant", i), ov,
        mk(v.exp_sel == 1'b0, v.exp_sel == 1'b1, 1'b1, v.exp_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    if (v.dly == 0) seq_done_i = 1'b1;
    for (int k = 1; k <= endc + int'(v.hold); k++) begin
      @(negedge mem_clk);
      seq_done_i = 1'b0;
      gnt = (k < endc);
      fin = (k == endc);
      bz  = (k < endc + int'(v.hold));
      chk($sformatf("v%0d cyc%0d", i, k), ov,
          mk(gnt && !v.exp_sel, gnt && v.exp_sel, 1'b0, bz && v.exp_sel, fin && to,
             fin && !to && !v.exp_sel, fin && !to && v.exp_sel, fin && to, bz));
      if (k == v.dly) seq_done_i = 1'b1;
      if (fin) cs_hold_i = 4'hF;  // must not affect the hold already loaded
    end
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy_o && n < 40) begin
      @(negedge mem_clk);
      n++;
    end
    total++;
    if (busy_o) begin
      bad++;
      $display("FAIL %s: busy still %b after %0d cycles, want 0", nm, busy_o, n);
    end
  endtask

  // Both paths hold requests; record which path owns each seq_start_o.
  task automatic back_to_back(string nm, logic prio, int nstart, logic [3:0] exp_own);
    int seen = 0;
    int cyc  = 0;
    logic [3:0] own = 4'd0;
    mem_prio_i = prio; cs_hold_i = 4'd1; tmo_limit_i = 16'd0;
    csr_req_i = 1'b1; mem_req_i = 1'b1;
    while (seen < nstart && cyc < 200) begin
      @(negedge mem_clk);
      cyc++;
      seq_done_i = 1'b0;
      if (seq_start_o) begin
        own[seen] = mem_gnt_o;
        seen++;
        seq_done_i = 1'b1;
      end
    end
    csr_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge mem_clk);
    seq_done_i = 1'b0;
    total++;
    if (seen != nstart || own != exp_own) begin
      bad++;
      $display("FAIL %s: starts=%0d owners=%b want starts=%0d owners=%b",
               nm, seen, own, nstart, exp_own);
    end
    wait_idle({nm, " idle"});
  endtask

  initial begin
    tbl[0] = mkv(1'b1, 1'b0, 1'b0, 4'd3,  16'd0,  10, 1'b0);
    tbl[1] = mkv(1'b0, 1'b1, 1'b0, 4'd2,  16'd0,   3, 1'b1);
    tbl[2] = mkv(1'b1, 1'b1, 1'b0, 4'd0,  16'd0,   1, 1'b0);
    tbl[3] = mkv(1'b1, 1'b1, 1'b0, 4'd1,  16'd0,   5, 1'b1);
    tbl[4] = mkv(1'b1, 1'b1, 1'b1, 4'd1,  16'd0,   2, 1'b1);
    tbl[5] = mkv(1'b1, 1'b1, 1'b1, 4'd0,  16'd0,   0, 1'b1);
    tbl[6] = mkv(1'b1, 1'b1, 1'b0, 4'd2,  16'd20, -1, 1'b0);
    tbl[7] = mkv(1'b0, 1'b1, 1'b0, 4'd0,  16'd5,   5, 1'b1);
    tbl[8] = mkv(1'b1, 1'b0, 1'b0, 4'd15, 16'd1,  -1, 1'b0);
    tbl[9] = mkv(1'b1, 1'b1, 1'b0, 4'd1,  16'd3,   2, 1'b1);

    // Reset state, with requests already pending.
    csr_req_i = 1'b1; mem_req_i = 1'b1;
    #12;
    chk("reset state", ov, 9'd0);
    csr_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge mem_clk);
    mem_rst_n = 1'b1;

    // A done pulse while idle changes nothing.
    @(negedge mem_clk);
    seq_done_i = 1'b1;
    @(negedge mem_clk);
    seq_done_i = 1'b0;
    chk("idle done c1", ov, 9'd0);
    @(negedge mem_clk);
    chk("idle done c2", ov, 9'd0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset in the middle of an ACTIVE transfer clears outputs without a clock edge.
    @(negedge mem_clk);
    mem_req_i = 1'b1; tmo_limit_i = 16'd0; cs_hold_i = 4'd2;
    @(negedge mem_clk);
    mem_req_i = 1'b0;
    @(negedge mem_clk);
    chk("pre-reset active", ov, mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    #2 mem_rst_n = 1'b0;
    #1 chk("async reset", ov, 9'd0);
    @(negedge mem_clk);
    chk("held reset", ov, 9'd0);
    mem_rst_n = 1'b1;
    @(negedge mem_clk);
    chk("post reset", ov, 9'd0);

    // last_sel returns to its reset value, so CSR leads the round-robin.
    back_to_back("rr order", 1'b0, 4, 4'b1010);
    back_to_back("mem prio", 1'b1, 3, 4'b0111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
